serial_magnitude_comparator: RTL and testbench
==============================================

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; it SHALL be even and at least 2.
REQ-002 The block SHALL have parameter PAIRS, derived as WIDTH/2, giving the number of 2-bit digit pairs per compare.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin a compare; sampled on the rising edge.
REQ-006 Port A, input, WIDTH bits: unsigned operand A; sampled only on an accepted start.
REQ-007 Port B, input, WIDTH bits: unsigned operand B; sampled only on an accepted start.
REQ-008 Port busy, output, 1 bit: high while a compare is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a completed compare.
REQ-010 Port EQ, output, 1 bit: registered result, high when A == B.
REQ-011 Port GT, output, 1 bit: registered result, high when A > B.
REQ-012 Port LT, output, 1 bit: registered result, high when A < B.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted on the edge: latch A/B into shift registers, set running eq=1 and gt=0, clear the pair counter, go to RUN.
REQ-015 start SHALL be ignored in RUN, and busy SHALL be 1 exactly when state is RUN.
REQ-016 Each RUN edge SHALL process one 2-bit pair, MSB pair first: a and b are the top 2 bits of the shift registers, which then shift left by 2.
REQ-017 Each RUN step SHALL compute eq_next = eq AND (a == b), and gt_next = gt OR (eq AND a > b), with a and b unsigned.
REQ-018 Early termination: the RUN step that produces eq_next=0 SHALL be the completion step, even if pairs remain.
REQ-019 The RUN step that processes pair index PAIRS-1 SHALL always be the completion step.
REQ-020 On the completion edge, EQ, GT and LT SHALL be loaded as EQ=eq_next, GT=gt_next, LT=NOT eq_next AND NOT gt_next, and the state SHALL go to DONE.
REQ-021 EQ, GT and LT SHALL be one-hot after the first completion and SHALL hold their values until the next completion edge.
REQ-022 done SHALL be 1 exactly while in DONE, which lasts one cycle; with no start the next state SHALL be IDLE.
REQ-023 Latency: done SHALL be high in the cycle after the k-th RUN edge, where k is the 1-based index of the first differing pair (MSB first), or k = PAIRS if A == B.
REQ-024 With start held high continuously, a new compare SHALL be accepted on the DONE edge, giving one idle (DONE) cycle between runs.
REQ-025 Changes to A/B after acceptance SHALL NOT affect the compare in progress.

Reset
REQ-026 When reset=0, the block SHALL immediately (asynchronously) force state IDLE and busy=0, done=0, EQ=0, GT=0, LT=0, and clear the shift registers, counter, eq and gt.
REQ-027 Reset asserted during RUN SHALL abort the compare with no done pulse, and no stale result SHALL appear after reset.
REQ-028 After reset is released, the first rising edge SHALL be able to accept start.

Verification
REQ-029 Scenario, WIDTH=32: A=B=32'h1234_5678, start for 1 cycle -> busy high for 16 cycles, then done=1 with EQ=1, GT=0, LT=0.
REQ-030 Scenario: A=32'hC000_0000, B=32'h4000_0000 -> done 1 cycle after acceptance, GT=1, EQ=0, LT=0.
REQ-031 Scenario: A=32'h0000_0001, B=32'h0000_0002 -> done after 16 RUN cycles, LT=1; then A=0x2, B=0x1 -> GT=1.
REQ-032 Scenario: start pulsed again mid-RUN with different A/B -> ignored; the result matches the original operands.
REQ-033 Scenario: reset=0 asserted at RUN cycle 5 (A=B) -> all outputs 0 immediately and no done; after release a new compare completes correctly.
REQ-034 Scenario: exhaustive check with WIDTH=4 over all 256 A/B pairs, compared against a reference model -> EQ/GT/LT correct and done at cycle 1 or 2 per REQ-023.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: walks A and B two bits per cycle, MSB pair first,
// stopping at the first differing pair. WIDTH must be even and at least 2.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PAIRS = WIDTH / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int unsigned CntW = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               eq_res_q, eq_res_d;
    logic               gt_res_q, gt_res_d;
    logic               lt_res_q, lt_res_d;

    logic [1:0]         a_pair, b_pair;
    logic               eq_next, gt_next, last_pair;

    assign a_pair    = a_sr_q[WIDTH-1 -: 2];
    assign b_pair    = b_sr_q[WIDTH-1 -: 2];
    assign eq_next   = eq_q & (a_pair == b_pair);
    // gt can only be set while the higher pairs are still equal
    assign gt_next   = gt_q | (eq_q & (a_pair > b_pair));
    assign last_pair = (cnt_q == CntW'(PAIRS - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        cnt_d    = cnt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        eq_res_d = eq_res_q;
        gt_res_d = gt_res_q;
        lt_res_d = lt_res_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sr_d = a_sr_q << 2;
                b_sr_d = b_sr_q << 2;
                eq_d   = eq_next;
                gt_d   = gt_next;
                cnt_d  = cnt_q + CntW'(1);
                if (!eq_next || last_pair) begin
                    eq_res_d = eq_next;
                    gt_res_d = gt_next;
                    lt_res_d = ~eq_next & ~gt_next;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            cnt_q    <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            eq_res_q <= 1'b0;
            gt_res_q <= 1'b0;
            lt_res_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            cnt_q    <= cnt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            eq_res_q <= eq_res_d;
            gt_res_q <= gt_res_d;
            lt_res_q <= lt_res_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign EQ   = eq_res_q;
    assign GT   = gt_res_q;
    assign LT   = lt_res_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized and directed bench for serial_magnitude_comparator at WIDTH=32 and WIDTH=4,
// checked against a plain-arithmetic reference of result and latency.
module tb_serial_magnitude_comparator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, eq32, gt32, lt32;
    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, eq4, gt4, lt4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_magnitude_comparator #(.WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset), .start(start), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .EQ(eq32), .GT(gt32), .LT(lt32)
    );

    serial_magnitude_comparator #(.WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .EQ(eq4), .GT(gt4), .LT(lt4)
    );

    // 1-based index of the first differing 2-bit digit, MSB first; pairs when equal
    function automatic int ref_k(input int pairs, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < pairs; i++) begin
            int sh = 2 * (pairs - 1 - i);
            if (((a >> sh) & 32'd3) != ((b >> sh) & 32'd3)) return i + 1;
        end
        return pairs;
    endfunction

    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b);
        if (a == b) return 3'b100;
        if (a > b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one compare on the 32-bit DUT and measure how many RUN edges pass before done
    task automatic run32(input logic [31:0] a, input logic [31:0] b, output int cyc,
                         output int busy_cnt, output logic [2:0] res, output bit to);
        a32 = a;
        b32 = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (done32 !== 1'b1 && cyc < 40) begin
            if (busy32 === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
        to = (done32 !== 1'b1);
        res = {eq32, gt32, lt32};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({busy32, done32, eq32, gt32, lt32} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b required=00000", {busy32, done32, eq32, gt32, lt32});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_equal();
        int cyc, bc; logic [2:0] res; bit to;
        run32(32'h1234_5678, 32'h1234_5678, cyc, bc, res, to);
        checks++;
        if (to || cyc !== 16 || bc !== 16) begin
            errors++;
            $display("FAIL equal_latency cycles=%0d busy=%0d timeout=%0d required 16/16", cyc, bc, to);
        end
        checks++;
        if (res !== 3'b100) begin
            errors++;
            $display("FAIL equal_result got=%b required=100", res);
        end
        tick();
        checks++;
        if (done32 !== 1'b0 || busy32 !== 1'b0 || {eq32, gt32, lt32} !== 3'b100) begin
            errors++;
            $display("FAIL done_pulse_hold done=%b busy=%b res=%b required 0/0/100",
                     done32, busy32, {eq32, gt32, lt32});
        end
    endtask

    task automatic test_early();
        int cyc, bc; logic [2:0] res; bit to;
        run32(32'hC000_0000, 32'h4000_0000, cyc, bc, res, to);
        checks++;
        if (to || cyc !== 1 || res !== 3'b010) begin
            errors++;
            $display("FAIL early_gt cycles=%0d res=%b required 1/010", cyc, res);
        end
    endtask

    task automatic test_lt_gt();
        int cyc, bc; logic [2:0] res; bit to;
        run32(32'h1, 32'h2, cyc, bc, res, to);
        checks++;
        if (to || cyc !== 16 || res !== 3'b001) begin
            errors++;
            $display("FAIL lsb_lt cycles=%0d res=%b required 16/001", cyc, res);
        end
        run32(32'h2, 32'h1, cyc, bc, res, to);
        checks++;
        if (to || cyc !== 16 || res !== 3'b010) begin
            errors++;
            $display("FAIL lsb_gt cycles=%0d res=%b required 16/010", cyc, res);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        a32 = 32'h0000_0100;
        b32 = 32'h0000_0200;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a32 = 32'hFFFF_FFFF;
        b32 = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 4;
        while (done32 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 12 || {eq32, gt32, lt32} !== 3'b001) begin
            errors++;
            $display("FAIL ignore_start cycles=%0d res=%b required 12/001", cyc, {eq32, gt32, lt32});
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc; logic [2:0] res; bit to; bit saw_done;
        logic [31:0] v = $urandom;
        a32 = v;
        b32 = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy32, done32, eq32, gt32, lt32} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got=%b required=00000", {busy32, done32, eq32, gt32, lt32});
        end
        saw_done = 1'b0;
        repeat (3) begin
            tick();
            if (done32 !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (20) begin
            tick();
            if (done32 !== 1'b0 || {eq32, gt32, lt32} !== 3'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_abort got stale done/result required none");
        end
        run32(32'h8000_0000, 32'h8000_0001, cyc, bc, res, to);
        checks++;
        if (to || cyc !== 16 || res !== 3'b001) begin
            errors++;
            $display("FAIL post_reset cycles=%0d res=%b required 16/001", cyc, res);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] x1 = 32'h0F00_0000, y1 = 32'h0E00_0000;
        logic [31:0] x2 = 32'h5555_5554, y2 = 32'h5555_5556;
        a32 = x1;
        b32 = y1;
        start = 1'b1;
        tick();
        a32 = x2;
        b32 = y2;
        cyc = 0;
        while (done32 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== ref_k(16, x1, y1) || {eq32, gt32, lt32} !== ref_res(x1, y1)) begin
            errors++;
            $display("FAIL b2b_first cycles=%0d res=%b required %0d/%b", cyc, {eq32, gt32, lt32},
                     ref_k(16, x1, y1), ref_res(x1, y1));
        end
        tick();
        start = 1'b0;
        a32 = $urandom;
        b32 = $urandom;
        checks++;
        if (busy32 !== 1'b1 || done32 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b done=%b required 1/0", busy32, done32);
        end
        cyc = 0;
        while (done32 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== ref_k(16, x2, y2) || {eq32, gt32, lt32} !== ref_res(x2, y2)) begin
            errors++;
            $display("FAIL b2b_second cycles=%0d res=%b required %0d/%b", cyc, {eq32, gt32, lt32},
                     ref_k(16, x2, y2), ref_res(x2, y2));
        end
        tick();
    endtask

    task automatic test_random();
        int cyc, bc; logic [2:0] res; bit to;
        int bad = 0;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b;
            logic [31:0] flip = 32'($urandom_range(1, 3));
            case ($urandom_range(0, 2))
                0: b = $urandom;
                1: b = a;
                default: b = a ^ (flip << (2 * $urandom_range(0, 15)));
            endcase
            run32(a, b, cyc, bc, res, to);
            checks++;
            if (to || cyc !== ref_k(16, a, b) || bc !== cyc || res !== ref_res(a, b)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random a=%h b=%h cycles=%0d busy=%0d res=%b required %0d/%b",
                             a, b, cyc, bc, res, ref_k(16, a, b), ref_res(a, b));
            end
        end
    endtask

    task automatic test_exhaustive4();
        int cyc;
        int bad = 0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                logic [31:0] ea = 32'(ai);
                logic [31:0] eb = 32'(bi);
                a4 = 4'(ai);
                b4 = 4'(bi);
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                cyc = 0;
                while (done4 !== 1'b1 && cyc < 10) begin
                    tick();
                    cyc++;
                end
                checks++;
                if (cyc !== ref_k(2, ea, eb) || {eq4, gt4, lt4} !== ref_res(ea, eb)) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL exh4 a=%0d b=%0d cycles=%0d res=%b required %0d/%b",
                                 ai, bi, cyc, {eq4, gt4, lt4}, ref_k(2, ea, eb), ref_res(ea, eb));
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_equal();
        test_early();
        test_lt_gt();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_exhaustive4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
